// File: rtl/jtag_dmi_resp.sv
// ---------------------------------------------------------------------------
// jtag_dmi_resp
//
// Purpose:
//   Target-side responder for the JTAG DMI front end. A one-cycle request
//   strobe (wr_intf) either clears the sticky status (control request,
//   wr_addr[31] = 1) or starts an access into the debug-module register
//   file over a simple req/ack handshake. The result of the last read and
//   the DTM-style sticky status are held on rd_data / rd_status for the
//   front end's next capture. A watchdog aborts accesses that are never
//   acknowledged.
//
// Ports:
//   jtag_tck     in   1       sole clock, rising edge
//   jtag_trst_n  in   1       asynchronous active-low reset
//   wr_addr      in   32      request address (bit 31 = control request)
//   wr_data      in   32      request write data
//   wr_intf      in   1       request strobe, one cycle
//   wr_enab      in   1       1 = write, 0 = read (qualifies wr_intf)
//   rd_data      out  32      last read result
//   rd_status    out  2       00 ok, 10 failed, 11 busy (sticky)
//   dm_req       out  1       access request, held until ack or timeout
//   dm_we        out  1       access write enable
//   dm_addr      out  ADDR_W  access address
//   dm_wdata     out  32      access write data
//   dm_ack       in   1       access complete (only looked at while dm_req)
//   dm_rdata     in   32      read data, valid with dm_ack
//   dm_err       in   1       access error, valid with dm_ack
// ---------------------------------------------------------------------------
module jtag_dmi_resp #(
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              jtag_tck,
  input  logic              jtag_trst_n,
  input  logic [31:0]       wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              wr_intf,
  input  logic              wr_enab,
  output logic [31:0]       rd_data,
  output logic [1:0]        rd_status,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TCNT_MAX  = TW'(TIMEOUT_CYC);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_FAIL = 2'b10;
  localparam logic [1:0] ST_BUSY = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TW-1:0]     r_tcnt;
  logic [TW-1:0]     w_tcnt_nxt;
  logic              r_dm_we;
  logic              w_dm_we_nxt;
  logic [ADDR_W-1:0] r_dm_addr;
  logic [ADDR_W-1:0] w_dm_addr_nxt;
  logic [31:0]       r_dm_wdata;
  logic [31:0]       w_dm_wdata_nxt;
  logic [31:0]       r_rd_data;
  logic [31:0]       w_rd_data_nxt;
  logic [1:0]        r_rd_status;
  logic [1:0]        w_rd_status_nxt;

  logic              w_ctrl;
  logic              w_acc;
  logic              w_busy_hit;
  logic [1:0]        w_status_mid;
  logic              w_unused_addr;

  // Request decode. Only the low ADDR_W address bits reach the register
  // file; the remaining bits are folded into a deliberately unused net.
  assign w_ctrl        = wr_intf &  wr_addr[31];
  assign w_acc         = wr_intf & ~wr_addr[31];
  assign w_busy_hit    = w_acc & (r_state == S_WAIT);
  assign w_unused_addr = &{1'b0, wr_addr};

  // Status after the events of this cycle that happen "before" completion:
  // an access colliding with an outstanding one makes the status busy, and
  // a control request clears it. Completion / timeout are then judged
  // against this value, so a control request coincident with an ack lets
  // the ack result land normally.
  assign w_status_mid = w_busy_hit ? ST_BUSY :
                        w_ctrl     ? ST_OK   : r_rd_status;

  // State register and all datapath registers.
  always_ff @(posedge jtag_tck or negedge jtag_trst_n) begin
    if (!jtag_trst_n) begin
      r_state     <= S_IDLE;
      r_tcnt      <= '0;
      r_dm_we     <= 1'b0;
      r_dm_addr   <= '0;
      r_dm_wdata  <= '0;
      r_rd_data   <= '0;
      r_rd_status <= ST_OK;
    end else begin
      r_state     <= w_state_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_dm_we     <= w_dm_we_nxt;
      r_dm_addr   <= w_dm_addr_nxt;
      r_dm_wdata  <= w_dm_wdata_nxt;
      r_rd_data   <= w_rd_data_nxt;
      r_rd_status <= w_rd_status_nxt;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_tcnt_nxt      = r_tcnt;
    w_dm_we_nxt     = r_dm_we;
    w_dm_addr_nxt   = r_dm_addr;
    w_dm_wdata_nxt  = r_dm_wdata;
    w_rd_data_nxt   = r_rd_data;
    w_rd_status_nxt = w_status_mid;

    unique case (r_state)
      S_IDLE: begin
        // A new access is only launched while the status is clean; with a
        // sticky error pending it is silently dropped.
        if (w_acc && (r_rd_status == ST_OK)) begin
          w_dm_we_nxt    = wr_enab;
          w_dm_addr_nxt  = wr_addr[ADDR_W-1:0];
          w_dm_wdata_nxt = wr_data;
          w_tcnt_nxt     = '0;
          w_state_nxt    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (dm_ack) begin
          // Ack has priority over the watchdog, even in its final cycle.
          // A result is only recorded if nothing went wrong meanwhile.
          w_state_nxt = S_IDLE;
          if (w_status_mid == ST_OK) begin
            if (!r_dm_we) begin
              w_rd_data_nxt = dm_rdata;
            end
            w_rd_status_nxt = dm_err ? ST_FAIL : ST_OK;
          end
        end else if (r_tcnt == TCNT_LAST) begin
          // Watchdog expiry: dm_req has now been high TIMEOUT_CYC cycles.
          w_state_nxt = S_IDLE;
          if (w_status_mid == ST_OK) begin
            w_rd_status_nxt = ST_FAIL;
          end
        end else if (r_tcnt != TCNT_MAX) begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // dm_req is decoded straight from the state register so that reset
  // removes it asynchronously.
  assign dm_req    = (r_state == S_WAIT);
  assign dm_we     = r_dm_we;
  assign dm_addr   = r_dm_addr;
  assign dm_wdata  = r_dm_wdata;
  assign rd_data   = r_rd_data;
  assign rd_status = r_rd_status;

endmodule

// File: tb/tb_jtag_dmi_resp.sv
// Testbench for jtag_dmi_resp, run with TIMEOUT_CYC = 4. The bench plays
// the debug-module side itself and keeps a transaction-level model of the
// responder's visible state (last read data, sticky status).
module tb_jtag_dmi_resp;

  localparam int TOUT = 4;
  localparam int AW   = 7;

  logic          jtag_tck = 1'b0;
  logic          jtag_trst_n;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic          wr_intf;
  logic          wr_enab;
  logic [31:0]   rd_data;
  logic [1:0]    rd_status;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_ack;
  logic [31:0]   dm_rdata;
  logic          dm_err;

  int total = 0;
  int bad   = 0;

  // Reference model state: what the front end should capture next.
  logic [31:0] m_data;
  logic [1:0]  m_status;

  jtag_dmi_resp #(
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .jtag_tck    (jtag_tck),
    .jtag_trst_n (jtag_trst_n),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_intf     (wr_intf),
    .wr_enab     (wr_enab),
    .rd_data     (rd_data),
    .rd_status   (rd_status),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_ack      (dm_ack),
    .dm_rdata    (dm_rdata),
    .dm_err      (dm_err)
  );

  always #5 jtag_tck = ~jtag_tck;

  task automatic tick();
    @(posedge jtag_tck);
    #1;
  endtask

  // Transaction-level model of one access request. Returns the number of
  // cycles dm_req must be high (0 when the request is dropped).
  function automatic int model_access(input logic we, input logic [31:0] rdata,
                                      input int lat, input logic err,
                                      input bit inj, input bit ctrl_end);
    int endc;
    if (m_status != 2'b00) return 0;
    endc = (lat <= TOUT) ? lat : TOUT;
    if (inj && endc != 1) m_status = 2'b11;
    if (ctrl_end) m_status = 2'b00;
    if (lat <= TOUT) begin
      if (m_status == 2'b00) begin
        if (!we) m_data = rdata;
        m_status = err ? 2'b10 : 2'b00;
      end
    end else if (m_status == 2'b00) begin
      m_status = 2'b10;
    end
    return endc;
  endfunction

  // Issue one access strobe and act as the debug module: ack in the lat-th
  // dm_req cycle (never, if lat > TOUT). Optionally inject a colliding
  // access in the first wait cycle and/or a control request in the last.
  // Reports how long dm_req stayed high and whether the dm_* request
  // fields held the requested values throughout.
  task automatic do_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input int lat,
                           input logic err, input logic [31:0] rdata,
                           input bit inj, input bit ctrl_end,
                           output int hi, output bit stable_ok);
    int endc;
    logic [31:0] tmp;
    logic [AW-1:0] exp_addr;
    exp_addr = addr[AW-1:0];
    endc = (lat <= TOUT) ? lat : TOUT;
    wr_intf = 1'b1; wr_enab = we; wr_addr = addr; wr_data = data;
    tick();
    wr_intf = 1'b0; wr_enab = 1'b0;
    hi = 0;
    stable_ok = 1'b1;
    while (dm_req === 1'b1 && hi < 20) begin
      hi++;
      if (dm_we !== we || dm_addr !== exp_addr || dm_wdata !== data) stable_ok = 1'b0;
      if (hi == lat) begin
        dm_ack = 1'b1; dm_rdata = rdata; dm_err = err;
      end
      if (inj && hi == 1 && endc != 1) begin
        tmp = $urandom;
        wr_intf = 1'b1; wr_enab = tmp[0]; wr_addr = tmp & 32'h7fff_ffff;
      end
      if (ctrl_end && hi == endc) begin
        wr_intf = 1'b1; wr_addr = 32'h8000_0000;
      end
      tick();
      dm_ack = 1'b0; dm_err = 1'b0; wr_intf = 1'b0;
      dm_rdata = $urandom;
    end
  endtask

  task automatic send_ctrl();
    wr_intf = 1'b1; wr_enab = 1'b0; wr_addr = 32'h8000_0000; wr_data = $urandom;
    tick();
    wr_intf = 1'b0;
    m_status = 2'b00;
  endtask

  task automatic test_reset();
    jtag_trst_n = 1'b0;
    wr_addr = '0; wr_data = '0; wr_intf = 1'b0; wr_enab = 1'b0;
    dm_ack = 1'b0; dm_rdata = '0; dm_err = 1'b0;
    m_data = '0; m_status = 2'b00;
    #23;
    total++;
    if (dm_req !== 1'b0 || dm_we !== 1'b0 || dm_addr !== '0 || dm_wdata !== '0) begin
      bad++;
      $display("[TB] FAIL reset_dm: req=%b we=%b addr=%h wdata=%h exp all zero",
               dm_req, dm_we, dm_addr, dm_wdata);
    end
    total++;
    if (rd_data !== 32'h0 || rd_status !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_rd: rd_data=%h rd_status=%b exp 0/00", rd_data, rd_status);
    end
    jtag_trst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    int hi; bit ok; int exp_hi;
    exp_hi = model_access(1'b0, 32'h1234_5678, 3, 1'b0, 0, 0);
    do_access(1'b0, 32'h11, 32'h0, 3, 1'b0, 32'h1234_5678, 0, 0, hi, ok);
    total++;
    if (hi !== exp_hi || hi !== 3) begin
      bad++; $display("[TB] FAIL read_req_len: got %0d exp 3", hi);
    end
    total++;
    if (!ok) begin
      bad++; $display("[TB] FAIL read_fields: got unstable exp stable addr 11");
    end
    total++;
    if (rd_data !== 32'h1234_5678 || rd_status !== 2'b00) begin
      bad++;
      $display("[TB] FAIL read_result: got %h/%b exp 12345678/00", rd_data, rd_status);
    end
  endtask

  task automatic test_write();
    int hi; bit ok; int exp_hi; logic [31:0] prev;
    prev = m_data;
    exp_hi = model_access(1'b1, 32'hA5A5_A5A5, 2, 1'b1, 0, 0);
    do_access(1'b1, 32'h10, 32'hDEAD_BEEF, 2, 1'b1, 32'hA5A5_A5A5, 0, 0, hi, ok);
    total++;
    if (hi !== exp_hi || !ok) begin
      bad++; $display("[TB] FAIL write_req: got len %0d stable %0b exp len %0d stable 1", hi, ok, exp_hi);
    end
    total++;
    if (rd_data !== prev || rd_status !== 2'b10) begin
      bad++;
      $display("[TB] FAIL write_result: got %h/%b exp %h/10", rd_data, rd_status, prev);
    end
    send_ctrl();
  endtask

  task automatic test_busy();
    int hi; bit ok; int exp_hi; logic [31:0] prev;
    prev = m_data;
    exp_hi = model_access(1'b0, 32'hCAFE_0001, 3, 1'b0, 1, 0);
    do_access(1'b0, 32'h22, 32'h0, 3, 1'b0, 32'hCAFE_0001, 1, 0, hi, ok);
    total++;
    if (hi !== exp_hi || rd_status !== 2'b11 || rd_data !== prev) begin
      bad++;
      $display("[TB] FAIL busy_sticky: got len %0d %h/%b exp len %0d %h/11",
               hi, rd_data, rd_status, exp_hi, prev);
    end
    exp_hi = model_access(1'b0, 32'hCAFE_0002, 1, 1'b0, 0, 0);
    do_access(1'b0, 32'h23, 32'h0, 1, 1'b0, 32'hCAFE_0002, 0, 0, hi, ok);
    total++;
    if (hi !== 0 || exp_hi !== 0 || rd_status !== 2'b11) begin
      bad++;
      $display("[TB] FAIL busy_drop: got len %0d status %b exp len 0 status 11", hi, rd_status);
    end
    send_ctrl();
    total++;
    if (rd_status !== 2'b00) begin
      bad++; $display("[TB] FAIL busy_clear: got %b exp 00", rd_status);
    end
    exp_hi = model_access(1'b0, 32'hCAFE_0003, 2, 1'b0, 0, 0);
    do_access(1'b0, 32'h24, 32'h0, 2, 1'b0, 32'hCAFE_0003, 0, 0, hi, ok);
    total++;
    if (hi !== exp_hi || rd_data !== 32'hCAFE_0003 || rd_status !== 2'b00) begin
      bad++;
      $display("[TB] FAIL busy_recover: got len %0d %h/%b exp len %0d cafe0003/00",
               hi, rd_data, rd_status, exp_hi);
    end
  endtask

  task automatic test_timeout();
    int hi; bit ok; int exp_hi; logic [31:0] prev;
    prev = m_data;
    exp_hi = model_access(1'b0, 32'h0, 99, 1'b0, 0, 0);
    do_access(1'b0, 32'h30, 32'h0, 99, 1'b0, 32'h0, 0, 0, hi, ok);
    total++;
    if (hi !== TOUT || hi !== exp_hi || rd_status !== 2'b10) begin
      bad++;
      $display("[TB] FAIL timeout: got len %0d status %b exp len %0d status 10", hi, rd_status, TOUT);
    end
    dm_ack = 1'b1; dm_rdata = 32'hBAD0_BAD0; dm_err = 1'b0;
    tick();
    dm_ack = 1'b0;
    tick();
    total++;
    if (dm_req !== 1'b0 || rd_data !== prev || rd_status !== 2'b10) begin
      bad++;
      $display("[TB] FAIL late_ack: got req %b %h/%b exp req 0 %h/10", dm_req, rd_data, rd_status, prev);
    end
    send_ctrl();
  endtask

  task automatic test_boundaries();
    int hi; bit ok; int exp_hi;
    exp_hi = model_access(1'b0, 32'h4444_0004, TOUT, 1'b0, 0, 0);
    do_access(1'b0, 32'h40, 32'h0, TOUT, 1'b0, 32'h4444_0004, 0, 0, hi, ok);
    total++;
    if (hi !== exp_hi || rd_status !== 2'b00 || rd_data !== 32'h4444_0004) begin
      bad++;
      $display("[TB] FAIL ack_last_cycle: got len %0d %h/%b exp len %0d 44440004/00",
               hi, rd_data, rd_status, exp_hi);
    end
    exp_hi = model_access(1'b0, 32'h5555_0005, 2, 1'b1, 0, 1);
    do_access(1'b0, 32'h41, 32'h0, 2, 1'b1, 32'h5555_0005, 0, 1, hi, ok);
    total++;
    if (rd_status !== 2'b10 || rd_data !== m_data) begin
      bad++;
      $display("[TB] FAIL ctrl_with_ack_err: got %h/%b exp %h/10", rd_data, rd_status, m_data);
    end
    send_ctrl();
    exp_hi = model_access(1'b0, 32'h6666_0006, 3, 1'b0, 1, 1);
    do_access(1'b0, 32'h42, 32'h0, 3, 1'b0, 32'h6666_0006, 1, 1, hi, ok);
    total++;
    if (rd_status !== 2'b00 || rd_data !== 32'h6666_0006) begin
      bad++;
      $display("[TB] FAIL ctrl_clears_busy_at_ack: got %h/%b exp 66660006/00", rd_data, rd_status);
    end
    exp_hi = model_access(1'b0, 32'h0, 99, 1'b0, 0, 1);
    do_access(1'b0, 32'h43, 32'h0, 99, 1'b0, 32'h0, 0, 1, hi, ok);
    total++;
    if (hi !== TOUT || rd_status !== 2'b10) begin
      bad++;
      $display("[TB] FAIL ctrl_with_timeout: got len %0d status %b exp len %0d status 10",
               hi, rd_status, TOUT);
    end
    send_ctrl();
  endtask

  task automatic test_reset_mid();
    wr_intf = 1'b1; wr_enab = 1'b1; wr_addr = 32'h55; wr_data = 32'h1357_9BDF;
    tick();
    wr_intf = 1'b0;
    tick();
    #2;
    jtag_trst_n = 1'b0;
    #1;
    total++;
    if (dm_req !== 1'b0 || dm_we !== 1'b0 || dm_addr !== '0 || dm_wdata !== '0 ||
        rd_data !== 32'h0 || rd_status !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_mid_wait: req=%b we=%b addr=%h wdata=%h rd=%h st=%b exp all zero",
               dm_req, dm_we, dm_addr, dm_wdata, rd_data, rd_status);
    end
    #3;
    jtag_trst_n = 1'b1;
    m_data = '0; m_status = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    int hi; bit ok; int exp_hi;
    exp_hi = model_access(1'b0, 32'h7777_0001, 1, 1'b0, 0, 0);
    wr_intf = 1'b1; wr_enab = 1'b0; wr_addr = 32'h50; wr_data = 32'h0;
    tick();
    wr_intf = 1'b0;
    dm_ack = 1'b1; dm_rdata = 32'h7777_0001; dm_err = 1'b0;
    tick();
    dm_ack = 1'b0;
    total++;
    if (exp_hi !== 1 || dm_req !== 1'b0 || rd_data !== 32'h7777_0001 || rd_status !== 2'b00) begin
      bad++;
      $display("[TB] FAIL min_latency: got req %b %h/%b exp req 0 77770001/00", dm_req, rd_data, rd_status);
    end
    exp_hi = model_access(1'b0, 32'h7777_0002, 1, 1'b0, 0, 0);
    do_access(1'b0, 32'h51, 32'h0, 1, 1'b0, 32'h7777_0002, 0, 0, hi, ok);
    total++;
    if (hi !== exp_hi || !ok || rd_data !== 32'h7777_0002) begin
      bad++;
      $display("[TB] FAIL back_to_back: got len %0d %h exp len %0d 77770002", hi, rd_data, exp_hi);
    end
  endtask

  task automatic test_random();
    int hi; bit ok; int exp_hi; int lat;
    logic [31:0] r, addr, data, rdata;
    logic we, err;
    bit inj, ce;
    for (int i = 0; i < 80; i++) begin
      r = $urandom;
      if (r[2:0] == 3'd0) begin
        send_ctrl();
      end else begin
        addr  = $urandom; addr = addr & 32'h7fff_ffff;
        data  = $urandom;
        rdata = $urandom;
        we    = r[3];
        err   = (r[5:4] == 2'b00);
        inj   = (r[8:6] == 3'd0);
        ce    = (r[11:9] == 3'd0);
        lat   = int'($urandom_range(1, TOUT + 2));
        exp_hi = model_access(we, rdata, lat, err, inj, ce);
        do_access(we, addr, data, lat, err, rdata, inj, ce, hi, ok);
        total++;
        if (hi !== exp_hi || (hi > 0 && !ok)) begin
          bad++;
          $display("[TB] FAIL rnd_req[%0d]: got len %0d stable %0b exp len %0d stable 1",
                   i, hi, ok, exp_hi);
        end
      end
      total++;
      if (rd_data !== m_data || rd_status !== m_status || dm_req !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rnd_result[%0d]: got %h/%b req %b exp %h/%b req 0",
                 i, rd_data, rd_status, dm_req, m_data, m_status);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_busy();
    test_timeout();
    test_boundaries();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
